// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among NCH byte-stream requesters.
// Each granted packet is prefixed by a channel tag byte; grants are capped at MAXLEN data bytes.
module uart_tx_sched #(
    parameter int          NCH      = 4,
    parameter logic [7:0]  TAG_BASE = 8'hA0,
    parameter int          MAXLEN   = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NCH-1:0]           req_valid,
    input  logic [NCH*8-1:0]         req_data,
    input  logic [NCH-1:0]           req_last,
    output logic [NCH-1:0]           req_ready,
    output logic                     uart_transmit,
    output logic [7:0]               uart_tx_byte,
    input  logic                     uart_tx_free,
    output logic                     busy,
    output logic [$clog2(NCH)-1:0]   active_ch
);

    localparam int          CW   = $clog2(NCH);
    localparam int          NW   = $clog2(MAXLEN + 1);
    localparam int unsigned NCHU = NCH;

    typedef enum logic [1:0] {IDLE, TAG, DATA} state_t;

    state_t        state, state_n;
    logic [CW-1:0] g, g_n;
    logic [CW-1:0] last, last_n;
    logic [CW-1:0] pick;
    logic [NW-1:0] cnt, cnt_n;
    logic          any_req;
    logic          g_valid;
    logic          g_last;
    logic [7:0]    g_data;

    // First requester searching upward from last+1, wrapping modulo NCH.
    always_comb begin
        int unsigned idx;
        logic [CW-1:0] idx_c;
        pick    = '0;
        any_req = 1'b0;
        idx     = 0;
        idx_c   = '0;
        for (int unsigned i = 1; i <= NCHU; i++) begin
            idx   = (32'(last) + i) % NCHU;
            idx_c = CW'(idx);
            if (!any_req && req_valid[idx_c]) begin
                any_req = 1'b1;
                pick    = idx_c;
            end
        end
    end

    always_comb begin
        g_valid = req_valid[g];
        g_last  = req_last[g];
        g_data  = req_data[{g, 3'b000} +: 8];
    end

    always_comb begin
        state_n       = state;
        g_n           = g;
        last_n        = last;
        cnt_n         = cnt;
        uart_transmit = 1'b0;
        uart_tx_byte  = '0;
        req_ready     = '0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    g_n     = pick;
                    cnt_n   = '0;
                    state_n = TAG;
                end
            end
            TAG: begin
                if (uart_tx_free) begin
                    uart_transmit = 1'b1;
                    uart_tx_byte  = TAG_BASE + 8'(g);
                    state_n       = DATA;
                end
            end
            DATA: begin
                if (uart_tx_free && g_valid) begin
                    uart_transmit = 1'b1;
                    uart_tx_byte  = g_data;
                    req_ready[g]  = 1'b1;
                    cnt_n         = cnt + NW'(1);
                    // A forced end at MAXLEN re-arbitrates without any marker byte.
                    if (g_last || cnt == NW'(MAXLEN - 1)) begin
                        last_n  = g;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            g         <= '0;
            last      <= CW'(NCH - 1);
            cnt       <= '0;
            active_ch <= '0;
        end else begin
            state <= state_n;
            g     <= g_n;
            last  <= last_n;
            cnt   <= cnt_n;
            if (state == IDLE && any_req)
                active_ch <= pick;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: packet sources, a paced UART model and an
// expected-byte-stream model built from packet contents, tag rule and MAXLEN splitting.
module tb_uart_tx_sched;

    localparam int         NCH    = 4;
    localparam int         MAXLEN = 4;
    localparam logic [7:0] TB     = 8'hA0;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NCH-1:0]   req_valid = '0;
    logic [NCH*8-1:0] req_data = '0;
    logic [NCH-1:0]   req_last = '0;
    logic [NCH-1:0]   req_ready;
    logic             uart_transmit;
    logic [7:0]       uart_tx_byte;
    logic             uart_tx_free = 1'b1;
    logic             busy;
    logic [1:0]       active_ch;

    always #5 clk = ~clk;

    uart_tx_sched #(.NCH(NCH), .TAG_BASE(TB), .MAXLEN(MAXLEN)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .uart_transmit(uart_transmit),
        .uart_tx_byte (uart_tx_byte),
        .uart_tx_free (uart_tx_free),
        .busy         (busy),
        .active_ch    (active_ch)
    );

    int total = 0;
    int bad   = 0;

    // Source entries: [9]=gap marker (count in [7:0]), [8]=last, [7:0]=data.
    logic [9:0] src_q [NCH][$];
    logic [7:0] exp_q [$];
    int         frame = 3;
    int         fcnt  = 0;
    int         cyc   = 0;
    int         strobe_cyc = 0;
    int         fall_cyc   = 0;
    int         rdy_cnt [NCH];
    logic       busy_prev = 1'b0;

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Source and UART model: sample handshakes at negedge, apply after the edge.
    initial begin
        logic [NCH-1:0] rdy_s;
        logic           tx_s;
        forever begin
            @(negedge clk);
            rdy_s = req_ready;
            tx_s  = uart_transmit;
            @(posedge clk);
            #1;
            if (tx_s) begin
                uart_tx_free = 1'b0;
                fcnt         = frame;
            end else if (!uart_tx_free) begin
                fcnt--;
                if (fcnt <= 0) uart_tx_free = 1'b1;
            end
            for (int c = 0; c < NCH; c++) begin
                if (rdy_s[c] && src_q[c].size() > 0) void'(src_q[c].pop_front());
                if (src_q[c].size() > 0 && src_q[c][0][9]) begin
                    if (src_q[c][0][7:0] == 8'd0) void'(src_q[c].pop_front());
                    else src_q[c][0] = src_q[c][0] - 10'd1;
                end
                if (src_q[c].size() > 0 && !src_q[c][0][9]) begin
                    req_valid[c]        = 1'b1;
                    req_last[c]         = src_q[c][0][8];
                    req_data[c*8 +: 8]  = src_q[c][0][7:0];
                end else begin
                    req_valid[c]        = 1'b0;
                    req_last[c]         = 1'b0;
                    req_data[c*8 +: 8]  = 8'h00;
                end
            end
        end
    end

    // Compare process: every strobe against the expected stream, plus handshake rules.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                busy_prev = 1'b0;
            end else begin
                if (uart_transmit) begin
                    chk("strobe_when_free", int'(uart_tx_free), 1);
                    strobe_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_strobe: got %0h expected none", uart_tx_byte);
                    end else begin
                        chk("uart_byte", int'(uart_tx_byte), int'(exp_q.pop_front()));
                    end
                end
                if (req_ready != '0) begin
                    chk("ready_onehot", $countones(req_ready), 1);
                    for (int c = 0; c < NCH; c++) begin
                        if (req_ready[c]) begin
                            rdy_cnt[c]++;
                            chk("ready_valid", int'(req_valid[c]), 1);
                            chk("ready_strobe", int'(uart_transmit), 1);
                            chk("ready_data", int'(uart_tx_byte), int'(req_data[c*8 +: 8]));
                        end
                    end
                end
                if (busy_prev && !busy) fall_cyc = cyc;
                busy_prev = busy;
            end
        end
    end

    task automatic clear_all();
        for (int c = 0; c < NCH; c++) begin
            src_q[c].delete();
            rdy_cnt[c] = 0;
        end
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        clear_all();
    endtask

    task automatic release_rst();
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    task automatic load_pkt(input int ch, input int first, input int step, input int n,
                            input int gap_after, input int gap_len);
        for (int i = 0; i < n; i++) begin
            if (gap_len > 0 && i == gap_after) src_q[ch].push_back({1'b1, 1'b0, 8'(gap_len)});
            src_q[ch].push_back({1'b0, (i == n - 1), 8'(first + i * step)});
        end
    endtask

    // Expected UART stream for one packet: a tag opens every MAXLEN-byte grant.
    task automatic expect_pkt(input int ch, input int first, input int step, input int n);
        for (int i = 0; i < n; i++) begin
            if (i % MAXLEN == 0) exp_q.push_back(TB + 8'(ch));
            exp_q.push_back(8'(first + i * step));
        end
    endtask

    task automatic lit(input logic [7:0] b);
        exp_q.push_back(b);
    endtask

    task automatic wait_drain(input string name, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, int'(ok), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_all();
        repeat (3) @(posedge clk);
        #3;
        chk("rst_transmit", int'(uart_transmit), 0);
        chk("rst_byte", int'(uart_tx_byte), 0);
        chk("rst_ready", int'(req_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_active_ch", int'(active_ch), 0);

        // Single channel 2 packet 11,22,33.
        do_reset();
        lit(8'hA2); lit(8'h11); lit(8'h22); lit(8'h33);
        load_pkt(2, 8'h11, 8'h11, 3, 0, 0);
        release_rst();
        wait_drain("t1_drain", 200);
        repeat (4) @(posedge clk);
        chk("t1_ready_pulses", rdy_cnt[2], 3);
        chk("t1_busy_fall", fall_cyc - strobe_cyc, 1);
        chk("t1_active_ch", int'(active_ch), 2);
        chk("t1_busy_idle", int'(busy), 0);

        // Channels 0 and 1 alternate with 1-byte packets.
        do_reset();
        expect_pkt(0, 8'h01, 0, 1);
        expect_pkt(1, 8'h81, 0, 1);
        expect_pkt(0, 8'h02, 0, 1);
        expect_pkt(1, 8'h82, 0, 1);
        load_pkt(0, 8'h01, 0, 1, 0, 0);
        load_pkt(0, 8'h02, 0, 1, 0, 0);
        load_pkt(1, 8'h81, 0, 1, 0, 0);
        load_pkt(1, 8'h82, 0, 1, 0, 0);
        release_rst();
        wait_drain("t2_drain", 300);
        repeat (4) @(posedge clk);
        chk("t2_ready0", rdy_cnt[0], 2);
        chk("t2_ready1", rdy_cnt[1], 2);

        // MAXLEN split: 6 bytes on channel 3 become two grants.
        do_reset();
        lit(8'hA3); lit(8'h01); lit(8'h02); lit(8'h03); lit(8'h04);
        lit(8'hA3); lit(8'h05); lit(8'h06);
        load_pkt(3, 8'h01, 1, 6, 0, 0);
        release_rst();
        wait_drain("t3_drain", 300);
        repeat (4) @(posedge clk);
        chk("t3_ready3", rdy_cnt[3], 6);

        // Mid-packet valid gap on channel 0 keeps the grant over channel 1.
        do_reset();
        expect_pkt(0, 8'h10, 1, 3);
        expect_pkt(1, 8'h50, 0, 1);
        load_pkt(0, 8'h10, 1, 3, 2, 20);
        load_pkt(1, 8'h50, 0, 1, 0, 0);
        release_rst();
        wait_drain("t4_drain", 400);
        repeat (4) @(posedge clk);
        chk("t4_ready1", rdy_cnt[1], 1);

        // Slow UART: 40 busy cycles per frame.
        do_reset();
        frame = 40;
        expect_pkt(1, 8'hB1, 0, 1);
        expect_pkt(2, 8'hC1, 1, 3);
        load_pkt(2, 8'hC1, 1, 3, 0, 0);
        load_pkt(1, 8'hB1, 0, 1, 0, 0);
        release_rst();
        wait_drain("t5_drain", 1000);
        repeat (45) @(posedge clk);
        frame = 3;
        chk("t5_ready2", rdy_cnt[2], 3);

        // Reset in DATA after 2 of 5 bytes.
        do_reset();
        lit(8'hA2); lit(8'h21); lit(8'h22);
        load_pkt(2, 8'h21, 1, 5, 0, 0);
        release_rst();
        wait_drain("t6_two_bytes", 200);
        #3;
        chk("t6_busy_before", int'(busy), 1);
        chk("t6_active_before", int'(active_ch), 2);
        rst = 1'b1;
        #1;
        chk("t6_rst_transmit", int'(uart_transmit), 0);
        chk("t6_rst_byte", int'(uart_tx_byte), 0);
        chk("t6_rst_ready", int'(req_ready), 0);
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_active", int'(active_ch), 0);
        clear_all();
        expect_pkt(1, 8'h61, 0, 1);
        load_pkt(1, 8'h61, 0, 1, 0, 0);
        release_rst();
        wait_drain("t6_ch1_only", 200);
        repeat (4) @(posedge clk);

        do_reset();
        expect_pkt(0, 8'h70, 0, 1);
        expect_pkt(1, 8'h71, 0, 1);
        load_pkt(0, 8'h70, 0, 1, 0, 0);
        load_pkt(1, 8'h71, 0, 1, 0, 0);
        release_rst();
        wait_drain("t6_ch0_first", 200);
        repeat (4) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares the single UART transmitter among NCH byte-stream requesters. Each requester presents packets on a valid/ready/last handshake. The scheduler grants one channel per packet, emits a channel tag byte, and then streams that channel's bytes into the UART `transmit`/`tx_byte` inputs, pacing on `tx_free`. It sits between the trace/host-message sources and the UART transmit path.

## Interface
- `NCH`, 4: number of requesters, 2..16.
- `TAG_BASE`, 8'hA0: tag byte value is `TAG_BASE + channel index` (8-bit, wraps).
- `MAXLEN`, 64: maximum data bytes per grant, 1..255; forces re-arbitration.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in NCH: per-channel byte valid.
- `req_data` in NCH*8: per-channel byte; channel i occupies bits [8i+7:8i].
- `req_last` in NCH: per-channel last-byte-of-packet flag, qualified by valid.
- `req_ready` out NCH: per-channel byte accepted this cycle.
- `uart_transmit` out 1: one-cycle start strobe to the UART.
- `uart_tx_byte` out 8: byte to the UART, meaningful only while `uart_transmit` is high.
- `uart_tx_free` in 1: UART transmitter idle; it goes low the cycle after an accepted strobe.
- `busy` out 1: scheduler holds a grant (state ≠ IDLE).
- `active_ch` out clog2(NCH): currently or last granted channel.

## Operation
- States:
  - IDLE
    - If any `req_valid` is high, load grant `g` = first requesting channel searching upward from `last+1` (mod NCH), clear the byte counter, and go to TAG.
    - Otherwise stay in IDLE.
  - TAG
    - While `uart_tx_free` is high: `uart_transmit`=1, `uart_tx_byte`=`TAG_BASE+g`, then go to DATA.
    - Otherwise wait.
  - DATA
    - While `uart_tx_free` and `req_valid[g]` are both high: `uart_transmit`=1, `uart_tx_byte`=`req_data[g]`, `req_ready[g]`=1, and increment the counter.
    - If `req_last[g]` is high or counter==MAXLEN-1, set `last`=`g` and go to IDLE.
- `uart_transmit`, `uart_tx_byte` and `req_ready` are combinational decodes of state, `g`, `uart_tx_free` and `req_valid[g]`. `req_ready` is never high for any channel other than `g`, and never high outside DATA.
- A valid gap mid-packet keeps the grant; there is no timeout. Other channels wait.
- A forced end at MAXLEN inserts no marker. The remainder of the packet is sent under a fresh tag after the next arbitration win.
- The grant is evaluated only in IDLE. Valid changes on other channels during a grant have no effect.
- Counter width is clog2(MAXLEN+1). It is cleared on entry to TAG and never wraps.

## Timing
- Reset (asynchronous):
  - State=IDLE, `last`=NCH-1 (so channel 0 wins first), `g`=0, counter=0.
  - Outputs: `uart_transmit`=0, `uart_tx_byte`=0, `req_ready`=0, `busy`=0, `active_ch`=0.
  - Takes effect immediately mid-packet. A byte already strobed into the UART completes there.
- Latency:
  - `req_valid` first seen in IDLE → tag strobe at the earliest one cycle later (TAG with `tx_free`=1).
  - Each data strobe occurs in the first DATA cycle with `tx_free`=1 and `req_valid[g]`=1.
- Double-strobe rule: after any strobe, `tx_free` is low in the following cycle, so the scheduler never strobes twice into one UART frame. The scheduler never asserts `uart_transmit` while `uart_tx_free` is low.
- Packet ending (last or MAXLEN): IDLE is occupied for exactly one cycle before TAG. The tag for the next packet waits on `tx_free` like any byte.
- Handshake: a byte transfers on the cycle `req_valid[g]` & `req_ready[g]`. The source must hold `req_data`/`req_last` stable until then.
- `active_ch` is registered and updates on IDLE→TAG. `busy` is registered state decode.

## Test plan
- Channel 2 only, packet 11,22,33 with last on 33, `TAG_BASE`=A0 → UART receives A2,11,22,33; `req_ready[2]` pulses 3 times; `busy` falls 1 cycle after the last strobe.
- Channels 0 and 1 both valid from reset with 1-byte packets, repeating → tags sequence A0,A1,A0,A1; no channel is granted twice while the other waits.
- `MAXLEN`=4, channel 3 sends 6 bytes 01..06 with last on 06, channel 1 idle → A3,01,02,03,04,A3,05,06.
- Channel 0 drops valid for 20 cycles mid-packet while channel 1 is valid → no `req_ready[1]` and no strobe until channel 0 finishes its packet.
- UART model holding `tx_free` low for 40 cycles per byte → exactly one strobe per frame; `uart_transmit` is never high while `tx_free`=0.
- `rst` asserted in DATA after 2 of 5 bytes → all outputs are 0 that same cycle. After release with channel 1 valid, the next tag is A1 only if channel 0 is idle; if channel 0 is also valid, the next tag is A0.
